// File: rtl/conv_frame_loader.sv
// rtl/conv_frame_loader.sv - serial kernel/frame loader feeding a convolution stage
// Optional: CONV_FRAME_LOADER_KEEP_KERNEL_EN retains the kernel across frames.
module conv_frame_loader #(
   parameter int inlen   = 255,
   parameter int kernlen = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               s_data,
   input  logic               s_valid,
   output logic               s_ready,
   output logic [inlen-1:0]   out_in,
   output logic [kernlen-1:0] out_kernel,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               loading_kernel
);

   localparam int maxlen = (inlen > kernlen) ? inlen : kernlen;
   localparam int cw     = $clog2(maxlen) + 1;

   localparam logic [1:0] LOAD_KERN = 2'd0;
   localparam logic [1:0] LOAD_DATA = 2'd1;
   localparam logic [1:0] HOLD      = 2'd2;

   localparam logic [cw-1:0] kern_last = cw'(kernlen - 1);
   localparam logic [cw-1:0] data_last = cw'(inlen - 1);

   logic [1:0]    state;
   logic [cw-1:0] bit_cnt;
   logic          accept;

`ifdef CONV_FRAME_LOADER_KEEP_KERNEL_EN
   logic          kern_loaded;
`endif

   // Handshake outputs are pure state decodes so s_ready never waits on s_valid.
   assign s_ready        = (state != HOLD);
   assign out_valid      = (state == HOLD);
   assign loading_kernel = (state == LOAD_KERN);
   assign accept         = s_valid && s_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= LOAD_KERN;
         bit_cnt    <= '0;
         out_in     <= '0;
         out_kernel <= '0;
`ifdef CONV_FRAME_LOADER_KEEP_KERNEL_EN
         kern_loaded <= 1'b0;
`endif
      end else begin
         case (state)
            LOAD_KERN: begin
               if (accept) begin
                  out_kernel <= {out_kernel[kernlen-2:0], s_data};
                  if (bit_cnt == kern_last) begin
                     state   <= LOAD_DATA;
                     bit_cnt <= '0;
`ifdef CONV_FRAME_LOADER_KEEP_KERNEL_EN
                     kern_loaded <= 1'b1;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + cw'(1);
                  end
               end
            end
            LOAD_DATA: begin
               if (accept) begin
                  out_in <= {out_in[inlen-2:0], s_data};
                  if (bit_cnt == data_last) begin
                     state   <= HOLD;
                     bit_cnt <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + cw'(1);
                  end
               end
            end
            HOLD: begin
               // Registers stay frozen here; only the downstream handshake moves us on.
               if (out_ready) begin
                  bit_cnt <= '0;
`ifdef CONV_FRAME_LOADER_KEEP_KERNEL_EN
                  state <= kern_loaded ? LOAD_DATA : LOAD_KERN;
`else
                  state <= LOAD_KERN;
`endif
               end
            end
            default: begin
               state   <= LOAD_KERN;
               bit_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv_frame_loader.sv
// tb/tb_conv_frame_loader.sv - randomized self-checking bench for conv_frame_loader
// Honours CONV_FRAME_LOADER_KEEP_KERNEL_EN in its reference model.
module tb_conv_frame_loader;
   localparam int INLEN   = 8;
   localparam int KERNLEN = 3;

   logic               clk = 1'b0;
   logic               rst;
   logic               s_data;
   logic               s_valid;
   logic               s_ready;
   logic [INLEN-1:0]   out_in;
   logic [KERNLEN-1:0] out_kernel;
   logic               out_valid;
   logic               out_ready;
   logic               loading_kernel;

   int tests_run    = 0;
   int tests_failed = 0;

   conv_frame_loader #(.inlen(INLEN), .kernlen(KERNLEN)) dut (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .out_in(out_in), .out_kernel(out_kernel), .out_valid(out_valid),
      .out_ready(out_ready), .loading_kernel(loading_kernel)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: captures each out_valid pulse, its frame and its length.
   int               ov_rises = 0;
   int               ov_rise_cyc = 0;
   int               ov_len = 0;
   int               last_len = 0;
   logic             ov_prev = 1'b0;
   logic [INLEN-1:0] ov_in = '0;
   logic [KERNLEN-1:0] ov_kern = '0;
   int               first_cyc = 0;
   bit               track_first = 1'b0;

   always @(negedge clk) begin
      if (track_first && s_valid && s_ready) begin
         first_cyc   = cyc;
         track_first = 1'b0;
      end
      if (out_valid && !ov_prev) begin
         ov_rises++;
         ov_rise_cyc = cyc;
         ov_in       = out_in;
         ov_kern     = out_kernel;
         ov_len      = 0;
      end
      if (out_valid) ov_len++;
      else if (ov_prev) last_len = ov_len;
      ov_prev = out_valid;
   end

   // Reference model: the kernel is the most recent complete kernel stream,
   // the frame is the most recent 8 data bits (first bit sent = MSB).
`ifdef CONV_FRAME_LOADER_KEEP_KERNEL_EN
   bit keep_mode = 1'b1;
`else
   bit keep_mode = 1'b0;
`endif
   bit                 kern_known = 1'b0;
   logic [KERNLEN-1:0] exp_kern = '0;
   logic [INLEN-1:0]   exp_in = '0;
   int                 rises_before = 0;

   task automatic push_bits(input logic [15:0] bits, input int n, input bit stall, output int idle);
      idle = 0;
      for (int i = n - 1; i >= 0; i--) begin
         bit done = 1'b0;
         int guard = 0;
         s_valid = 1'b1;
         s_data  = bits[i];
         while (!done) begin
            @(negedge clk);
            done = s_ready;
            @(posedge clk); #1;
            guard++;
            if (!done && guard > 50) begin
               tests_run++; tests_failed++;
               $display("FAIL push_timeout bit %0d never accepted, required acceptance within 50 cycles", i);
               done = 1'b1;
            end
         end
         if (stall && i > 0) begin
            s_valid = 1'b0;
            s_data  = 1'($urandom);
            @(posedge clk); #1;
            idle++;
         end
      end
      s_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [KERNLEN-1:0] k, input logic [INLEN-1:0] d,
                             input bit stall, output int idle, output int nbits);
      bit need = !(keep_mode && kern_known);
      logic [15:0] v;
      if (need) begin v = {5'b0, k, d}; nbits = KERNLEN + INLEN; end
      else      begin v = {8'b0, d};    nbits = INLEN; end
      rises_before = ov_rises;
      track_first  = 1'b1;
      push_bits(v, nbits, stall, idle);
      if (need) begin exp_kern = k; kern_known = 1'b1; end
      exp_in = d;
   endtask

   task automatic wait_ov(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(posedge clk); #1;
         ok = (ov_rises > rises_before);
      end
      if (!ok) begin
         tests_run++; tests_failed++;
         $display("FAIL out_valid_timeout got no out_valid, required one within 100 cycles");
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; s_valid = 1'b0; s_data = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests_run++;
      if ({out_in, out_kernel, out_valid, s_ready, loading_kernel} !== {8'h00, 3'b000, 1'b0, 1'b1, 1'b1}) begin
         tests_failed++;
         $display("FAIL reset_state got in=%h k=%b ov=%b rdy=%b lk=%b, required 00 000 0 1 1",
                  out_in, out_kernel, out_valid, s_ready, loading_kernel);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      kern_known = 1'b0;
   endtask

   task automatic test_basic();
      int idle, nbits;
      bit ok;
      out_ready = 1'b1;
      send_frame(3'b101, 8'b11001011, 1'b0, idle, nbits);
      wait_ov(ok);
      if (ok) begin
         tests_run++;
         if (ov_kern !== 3'b101 || ov_in !== 8'b11001011) begin
            tests_failed++;
            $display("FAIL basic_frame got k=%b in=%b, required k=101 in=11001011", ov_kern, ov_in);
         end
         // counting the first-accept cycle as cycle 1, out_valid lands on cycle 12
         tests_run++;
         if (ov_rise_cyc - first_cyc + 1 !== 12) begin
            tests_failed++;
            $display("FAIL basic_latency got %0d, required 12", ov_rise_cyc - first_cyc + 1);
         end
         repeat (2) @(negedge clk);
         tests_run++;
         if (last_len !== 1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_pulse_len got len=%0d ov=%b, required len=1 ov=0", last_len, out_valid);
         end
      end
   endtask

   task automatic test_stalls();
      int idle, nbits;
      bit ok;
      out_ready = 1'b1;
      @(posedge clk); #1;
      send_frame(3'b101, 8'b11001011, 1'b1, idle, nbits);
      wait_ov(ok);
      if (ok) begin
         tests_run++;
         if (ov_kern !== 3'b101 || ov_in !== 8'b11001011) begin
            tests_failed++;
            $display("FAIL stall_frame got k=%b in=%b, required k=101 in=11001011", ov_kern, ov_in);
         end
         tests_run++;
         if (ov_rise_cyc - first_cyc + 1 !== nbits + 1 + idle) begin
            tests_failed++;
            $display("FAIL stall_latency got %0d, required %0d", ov_rise_cyc - first_cyc + 1, nbits + 1 + idle);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_pressure();
      int idle, nbits;
      bit ok;
      logic [KERNLEN-1:0] k = 3'($urandom);
      logic [INLEN-1:0]   d = 8'($urandom);
      out_ready = 1'b0;
      send_frame(k, d, 1'b0, idle, nbits);
      wait_ov(ok);
      if (ok) begin
         for (int c = 0; c < 10; c++) begin
            s_valid = 1'b1; s_data = 1'($urandom);
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b1 || s_ready !== 1'b0 || out_in !== exp_in || out_kernel !== exp_kern) begin
               tests_failed++;
               $display("FAIL hold_cycle%0d got ov=%b rdy=%b in=%h k=%b, required ov=1 rdy=0 in=%h k=%b",
                        c, out_valid, s_ready, out_in, out_kernel, exp_in, exp_kern);
            end
            @(posedge clk); #1;
         end
         s_valid = 1'b0; out_ready = 1'b1;
         @(posedge clk); #1;
         k = 3'($urandom); d = 8'($urandom);
         send_frame(k, d, 1'b0, idle, nbits);
         wait_ov(ok);
         if (ok) begin
            tests_run++;
            if (ov_kern !== exp_kern || ov_in !== exp_in) begin
               tests_failed++;
               $display("FAIL after_hold_frame got k=%b in=%h, required k=%b in=%h", ov_kern, ov_in, exp_kern, exp_in);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_boundary();
      int idle, nbits, hs_cyc;
      bit ok;
      logic [INLEN-1:0] d = 8'($urandom);
      logic [KERNLEN-1:0] k = 3'($urandom);
      logic [15:0] v;
      out_ready = 1'b0;
      send_frame(k, d, 1'b0, idle, nbits);
      wait_ov(ok);
      if (ok) begin
         k = 3'($urandom); d = 8'($urandom);
         v = (keep_mode && kern_known) ? {8'b0, d} : {5'b0, k, d};
         nbits = (keep_mode && kern_known) ? INLEN : KERNLEN + INLEN;
         s_valid = 1'b1; s_data = v[nbits-1]; out_ready = 1'b1;
         @(negedge clk);
         hs_cyc = cyc;
         tests_run++;
         if (s_ready !== 1'b0 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL handshake_cycle got rdy=%b ov=%b, required rdy=0 ov=1", s_ready, out_valid);
         end
         @(posedge clk); #1;
         if (nbits == KERNLEN + INLEN) begin exp_kern = k; kern_known = 1'b1; end
         exp_in = d;
         rises_before = ov_rises;
         track_first  = 1'b1;
         push_bits(v, nbits, 1'b0, idle);
         wait_ov(ok);
         tests_run++;
         if (first_cyc !== hs_cyc + 1) begin
            tests_failed++;
            $display("FAIL first_accept_cycle got %0d, required %0d", first_cyc, hs_cyc + 1);
         end
         if (ok) begin
            tests_run++;
            if (ov_kern !== exp_kern || ov_in !== exp_in) begin
               tests_failed++;
               $display("FAIL boundary_frame got k=%b in=%h, required k=%b in=%h", ov_kern, ov_in, exp_kern, exp_in);
            end
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_two_frames();
      int idle, nbits;
      bit ok;
      out_ready = 1'b1;
      send_frame(3'b101, 8'h3C, 1'b0, idle, nbits);
      wait_ov(ok);
      @(posedge clk); #1;
      send_frame(3'b101, 8'hA5, 1'b0, idle, nbits);
      tests_run++;
      if (nbits !== (keep_mode ? INLEN : KERNLEN + INLEN)) begin
         tests_failed++;
         $display("FAIL second_stream_len got %0d, required %0d", nbits, keep_mode ? INLEN : KERNLEN + INLEN);
      end
      wait_ov(ok);
      if (ok) begin
         tests_run++;
         if (ov_kern !== 3'b101 || ov_in !== 8'hA5) begin
            tests_failed++;
            $display("FAIL second_frame got k=%b in=%h, required k=101 in=a5", ov_kern, ov_in);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_mid_reset();
      int idle, nbits;
      bit ok;
      out_ready = 1'b1;
      push_bits(16'h001B, 5, 1'b0, idle);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      kern_known = 1'b0;
      @(negedge clk);
      tests_run++;
      if (out_in !== 8'h00 || out_kernel !== 3'b000 || loading_kernel !== 1'b1 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_reset got in=%h k=%b lk=%b ov=%b, required 00 000 1 0",
                  out_in, out_kernel, loading_kernel, out_valid);
      end
      @(posedge clk); #1;
      send_frame(3'b110, 8'h96, 1'b0, idle, nbits);
      wait_ov(ok);
      if (ok) begin
         tests_run++;
         if (ov_kern !== 3'b110 || ov_in !== 8'h96) begin
            tests_failed++;
            $display("FAIL post_reset_frame got k=%b in=%h, required k=110 in=96", ov_kern, ov_in);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      int idle, nbits;
      bit ok;
      out_ready = 1'b1;
      for (int f = 0; f < 6; f++) begin
         send_frame(3'($urandom), 8'($urandom), 1'($urandom), idle, nbits);
         wait_ov(ok);
         if (ok) begin
            tests_run++;
            if (ov_kern !== exp_kern || ov_in !== exp_in) begin
               tests_failed++;
               $display("FAIL random_frame%0d got k=%b in=%h, required k=%b in=%h",
                        f, ov_kern, ov_in, exp_kern, exp_in);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stalls();
      test_back_pressure();
      test_boundary();
      test_two_frames();
      test_mid_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
